// File: rtl/lsu_pkg.sv
// Shared LSU types: FSM states, access size encodings and the byte-lane helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Lanes shifted past byte 3 fall off the 4-bit result.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_B:    lane_mask = 4'b0001 << a;
            SZ_H:    lane_mask = 4'b0011 << a;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        is_misaligned = ((size == SZ_H) && a[0]) || (size[1] && (a != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: store mask/shift and load shift/extend.
// Purely combinational, zero latency, no flow control.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    logic [4:0]  sh;
    logic [31:0] rd_sh;

    assign sh       = {addr_lo, 3'b000};
    assign wmask    = lane_mask(size, addr_lo);
    assign wdata_sh = wdata << sh;
    assign rd_sh    = rdata >> sh;

    always_comb begin
        rdata_ext = rd_sh;
        case (size)
            SZ_B:    rdata_ext = {{24{rd_sh[7]  & ~is_unsigned}}, rd_sh[7:0]};
            SZ_H:    rdata_ext = {{16{rd_sh[15] & ~is_unsigned}}, rd_sh[15:0]};
            default: rdata_ext = rd_sh;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit; load >=3 cycles accept->resp (bounded by TIMEOUT), store 2.
// req_ready only in IDLE, response is never back-pressured; LSU_MISALIGN_CHECK_EN faults misaligned half/word.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [7:0]  mem_wmask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        wen_q;
    logic [7:0]  cnt;
    logic        accept;
    logic        bad_align;
    logic [3:0]  lane_w;
    logic [31:0] wdata_sh;
    logic [31:0] rdata_ext;

    assign accept = req_valid && req_ready;

`ifdef LSU_MISALIGN_CHECK_EN
    assign bad_align = is_misaligned(req_size, req_addr[1:0]);
`else
    assign bad_align = 1'b0;
`endif

    lsu_align u_align (
        .size        (size_q),
        .addr_lo     (addr_q[1:0]),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata       (mem_rdata),
        .wmask       (lane_w),
        .wdata_sh    (wdata_sh),
        .rdata_ext   (rdata_ext)
    );

    assign mem_addr  = (state == RD_REQ || state == RD_WAIT || state == WR) ?
                       {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wmask = {4'b0000, (mem_wen ? lane_w : 4'b0000)};
    assign mem_wdata = wen_q ? wdata_sh : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            wen_q      <= 1'b0;
            cnt        <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_ren    <= 1'b0;
            mem_wen    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Ready rises one edge after reset release and stays up while idle.
                    req_ready <= 1'b1;
                    if (accept) begin
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        wen_q     <= req_wen;
                        req_ready <= 1'b0;
                        if (bad_align) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_wen) begin
                            state   <= WR;
                            mem_wen <= 1'b1;
                        end else begin
                            state   <= RD_REQ;
                            mem_ren <= 1'b1;
                        end
                    end
                end
                RD_REQ: begin
                    state   <= RD_WAIT;
                    mem_ren <= 1'b0;
                    cnt     <= '0;
                end
                RD_WAIT: begin
                    // Data arriving on the last allowed cycle still wins over the timeout.
                    if (mem_valid) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= rdata_ext;
                    end else if (cnt == CNT_LAST) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WR: begin
                    state      <= RESP;
                    mem_wen    <= 1'b0;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                    cnt        <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: transaction-level model plus per-cycle output compare.
module tb_lsu;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_ren;
    logic        mem_wen;
    logic [7:0]  mem_wmask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;

    lsu #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_ren      (mem_ren),
        .mem_wen      (mem_wen),
        .mem_wmask    (mem_wmask),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_valid    (mem_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  sz;
        logic        uns;
        int          lat;
        logic [31:0] mdata;
        logic        lit;
        logic [31:0] l_rdata;
        logic        l_err;
        int          l_lat;
        logic [7:0]  l_wmask;
        logic [31:0] l_wdata;
        logic [31:0] l_waddr;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc = -100, resp_cyc = -100, ren_cyc = -100, wen_cyc = -100, valid_cyc = -100;
    int rel_cyc = 0;
    logic [31:0] e_addr = '0, e_rdata = '0, e_wdata = '0, v_mdata = '0;
    logic [3:0]  e_wmask = '0;
    logic        e_err = 1'b0;
    logic [31:0] last_rdata = '0, last_wdata = '0, last_waddr = '0;
    logic [7:0]  last_wmask = '0;
    logic        last_err = 1'b0;
    int          last_resp_cyc = -1;
    int          resp_cnt = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] mem, input int a, input int nb, input logic uns);
        logic [31:0] s;
        logic [31:0] r;
        s = mem >> (8 * a);
        r = '0;
        for (int i = 0; i < 32; i++)
            r[i] = (i < 8 * nb) ? s[i] : (uns ? 1'b0 : s[8 * nb - 1]);
        return r;
    endfunction

    function automatic vec_t mk(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] sz, input logic uns, input int lat, input logic [31:0] mdata,
                                input logic lit, input logic [31:0] l_rdata, input logic l_err, input int l_lat,
                                input logic [7:0] l_wmask, input logic [31:0] l_wdata, input logic [31:0] l_waddr);
        vec_t v;
        v.wen = wen; v.addr = addr; v.wdata = wdata; v.sz = sz; v.uns = uns; v.lat = lat;
        v.mdata = mdata; v.lit = lit; v.l_rdata = l_rdata; v.l_err = l_err; v.l_lat = l_lat;
        v.l_wmask = l_wmask; v.l_wdata = l_wdata; v.l_waddr = l_waddr;
        return v;
    endfunction

    always @(posedge clk) cyc++;

    // Memory responder: answers on the scheduled cycle, strays mem_valid everywhere outside RD_WAIT.
    always @(posedge clk) begin
        #2;
        if (cyc == valid_cyc) begin
            mem_valid = 1'b1;
            mem_rdata = v_mdata;
        end else if (cyc >= acc + 2 && cyc < resp_cyc) begin
            mem_valid = 1'b0;
            mem_rdata = $urandom;
        end else begin
            mem_valid = ($urandom_range(0, 2) == 0);
            mem_rdata = 32'h5A5A_5A5A;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_req_ready", 32'(req_ready), 32'h0);
            chk("rst_resp_valid", 32'(resp_valid), 32'h0);
            chk("rst_resp_err", 32'(resp_err), 32'h0);
            chk("rst_resp_rdata", resp_rdata, 32'h0);
            chk("rst_mem_ren", 32'(mem_ren), 32'h0);
            chk("rst_mem_wen", 32'(mem_wen), 32'h0);
            chk("rst_mem_wmask", 32'(mem_wmask), 32'h0);
            chk("rst_mem_addr", mem_addr, 32'h0);
        end else begin
            chk("req_ready", 32'(req_ready), 32'((cyc > rel_cyc) && !(cyc > acc && cyc <= resp_cyc)));
            chk("mem_ren", 32'(mem_ren), 32'(cyc == ren_cyc));
            chk("mem_wen", 32'(mem_wen), 32'(cyc == wen_cyc));
            chk("ren_wen_excl", 32'(mem_ren & mem_wen), 32'h0);
            chk("resp_valid", 32'(resp_valid), 32'(cyc == resp_cyc));
            chk("mem_addr", mem_addr, (cyc > acc && cyc < resp_cyc) ? e_addr : 32'h0);
            chk("mem_wmask", 32'(mem_wmask), (cyc == wen_cyc) ? 32'(e_wmask) : 32'h0);
            if (mem_wen) begin
                chk("mem_wdata", mem_wdata, e_wdata);
                last_wmask = mem_wmask;
                last_wdata = mem_wdata;
                last_waddr = mem_addr;
            end
            if (resp_valid) begin
                chk("resp_rdata", resp_rdata, e_rdata);
                chk("resp_err", 32'(resp_err), 32'(e_err));
                last_rdata = resp_rdata;
                last_err = resp_err;
                last_resp_cyc = cyc;
                resp_cnt++;
            end
        end
    end

    task automatic issue(input vec_t v);
        int n;
        int a;
        int nb;
        logic mis;
        n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr; req_wdata = v.wdata;
        req_size = v.sz; req_unsigned = v.uns;
        while (!req_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) begin
            chk("accept_bound", 32'(req_ready), 32'h1);
            req_valid = 1'b0;
            return;
        end
        a = int'(v.addr[1:0]);
        nb = nbytes(v.sz);
        mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        mis = (nb == 2 && (a % 2) == 1) || (nb == 4 && a != 0);
`endif
        acc = cyc;
        e_addr = v.addr & 32'hFFFF_FFFC;
        ren_cyc = -100; wen_cyc = -100; valid_cyc = -100;
        e_err = 1'b0; e_rdata = '0;
        if (mis) begin
            resp_cyc = acc + 1;
            e_err = 1'b1;
        end else if (v.wen) begin
            wen_cyc = acc + 1;
            resp_cyc = acc + 2;
            e_wdata = v.wdata << (8 * a);
            for (int l = 0; l < 4; l++) e_wmask[l] = (l >= a) && (l < a + nb);
        end else begin
            ren_cyc = acc + 1;
            if (v.lat < 1 || v.lat > TO) begin
                resp_cyc = acc + 2 + TO;
                e_err = 1'b1;
            end else begin
                valid_cyc = acc + 1 + v.lat;
                resp_cyc = acc + 2 + v.lat;
                v_mdata = v.mdata;
                e_rdata = m_load(v.mdata, a, nb, v.uns);
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_wen = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_unsigned = 1'($urandom);
    endtask

    task automatic run_txn(input vec_t v);
        issue(v);
        while (cyc <= resp_cyc + 1) begin
            @(posedge clk); #1;
        end
        if (v.lit) begin
            chk("lit_rdata", last_rdata, v.l_rdata);
            chk("lit_err", 32'(last_err), 32'(v.l_err));
            chk("lit_latency", 32'(last_resp_cyc - acc), 32'(v.l_lat));
            if (v.wen) begin
                chk("lit_wmask", 32'(last_wmask), 32'(v.l_wmask));
                chk("lit_wdata", last_wdata, v.l_wdata);
                chk("lit_waddr", last_waddr, v.l_waddr);
            end
        end
    endtask

    vec_t vecs[12];
    vec_t mid;
    int   cnt_before;

    initial begin
        vecs[0]  = mk(0, 32'h8000_0004, 0, 2'd2, 0, 1,  32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 0, 3, 0, 0, 0);
        vecs[1]  = mk(0, 32'h8000_0003, 0, 2'd0, 0, 1,  32'h8000_0000, 1, 32'hFFFF_FF80, 0, 3, 0, 0, 0);
        vecs[2]  = mk(0, 32'h8000_0003, 0, 2'd0, 1, 1,  32'h8000_0000, 1, 32'h0000_0080, 0, 3, 0, 0, 0);
        vecs[3]  = mk(1, 32'h8000_0002, 32'h1234_ABCD, 2'd1, 0, 0, 0, 1, 32'h0, 0, 2, 8'h0C, 32'hABCD_0000, 32'h8000_0000);
        vecs[4]  = mk(0, 32'h8000_0010, 0, 2'd2, 0, 0,  32'h0, 1, 32'h0, 1, 2 + TO, 0, 0, 0);
        vecs[5]  = mk(0, 32'h8000_0002, 0, 2'd1, 0, 3,  32'h8001_7FFF, 1, 32'hFFFF_8001, 0, 5, 0, 0, 0);
        vecs[6]  = mk(1, 32'h8000_0001, 32'h0000_00A5, 2'd0, 0, 0, 0, 1, 32'h0, 0, 2, 8'h02, 32'h0000_A500, 32'h8000_0000);
        vecs[7]  = mk(1, 32'h8000_0008, 32'hCAFE_F00D, 2'd3, 0, 0, 0, 1, 32'h0, 0, 2, 8'h0F, 32'hCAFE_F00D, 32'h8000_0008);
        vecs[8]  = mk(0, 32'h8000_0000, 0, 2'd0, 0, TO, 32'h0000_007F, 1, 32'h0000_007F, 0, 2 + TO, 0, 0, 0);
        vecs[9]  = mk(0, 32'h8000_0001, 0, 2'd2, 0, 1,  32'h1122_3344, 0, 0, 0, 0, 0, 0, 0);
        vecs[10] = mk(0, 32'h8000_0001, 0, 2'd1, 1, 2,  32'hAABB_CCDD, 0, 0, 0, 0, 0, 0, 0);
        vecs[11] = mk(1, 32'h8000_0003, 32'h0000_BEEF, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mid      = mk(0, 32'h8000_0020, 0, 2'd2, 0, 0,  32'h0, 0, 0, 0, 0, 0, 0, 0);

        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        rel_cyc = cyc;

        for (int i = 0; i < 12; i++) run_txn(vecs[i]);

        // Reset while the load sits in RD_WAIT: outputs drop at once, no response follows.
        issue(mid);
        while (cyc < acc + 3) begin
            @(posedge clk); #1;
        end
        cnt_before = resp_cnt;
        rst = 1'b0;
        acc = -100; resp_cyc = -100; ren_cyc = -100; wen_cyc = -100; valid_cyc = -100;
        #1;
        chk("rstmid_mem_addr", mem_addr, 32'h0);
        chk("rstmid_mem_ren", 32'(mem_ren), 32'h0);
        chk("rstmid_req_ready", 32'(req_ready), 32'h0);
        chk("rstmid_resp_valid", 32'(resp_valid), 32'h0);
        chk("rstmid_mem_wmask", 32'(mem_wmask), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        rel_cyc = cyc;
        repeat (TO + 8) @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        chk("post_rst_no_resp", 32'(resp_cnt - cnt_before), 32'h0);

        run_txn(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=stuck want=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, maximum cycles to wait for mem_valid on a read (1..255).
REQ-002 SHALL have port: clk  input  1  sole clock, all state on posedge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  input  1  upstream access request.
REQ-005 SHALL have port: req_ready  output  1  lsu can accept a request this cycle.
REQ-006 SHALL have port: req_wen  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_addr  input  32  byte address.
REQ-008 SHALL have port: req_wdata  input  32  store data, right-aligned.
REQ-009 SHALL have port: req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
REQ-010 SHALL have port: req_unsigned  input  1  zero-extend load data when 1.
REQ-011 SHALL have port: resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: resp_rdata  output  32  extended load data, 0 for stores.
REQ-013 SHALL have port: resp_err  output  1  access failed; qualified by resp_valid.
REQ-014 SHALL have ports to the memory responder: mem_ren output 1, mem_wen output 1, mem_wmask output 8, mem_addr output 32, mem_wdata output 32, mem_rdata input 32, mem_valid input 1.

Function
REQ-015 SHALL use FSM states IDLE, RD_REQ, RD_WAIT, WR, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on req_valid&&req_ready.
REQ-017 SHALL register addr, wdata, size, unsigned and wen on accept; outputs use only the registered copies.
REQ-018 SHALL go IDLE->RD_REQ on an accepted load, and IDLE->WR on an accepted store.
REQ-019 SHALL drive mem_addr={addr[31:2],2'b00} in RD_REQ, RD_WAIT and WR; mem_addr=0 otherwise.
REQ-020 SHALL assert mem_ren for exactly one cycle (RD_REQ), then go to RD_WAIT.
REQ-021 SHALL, in RD_WAIT, capture mem_rdata on the first cycle mem_valid=1 and go to RESP.
REQ-022 SHALL assert mem_wen for exactly one cycle (WR), then go to RESP; mem_valid is not required for stores.
REQ-023 SHALL set mem_wmask[7:4]=0 always; mem_wmask[3:0] is 4'b0001<<a for byte, 4'b0011<<a for half, and 4'b1111 for word, where a=addr[1:0]; mem_wmask=0 when mem_wen=0.
REQ-024 SHALL drive mem_wdata = req_wdata shifted left by 8*addr[1:0].
REQ-025 SHALL form load data by shifting right by 8*addr[1:0], keeping 8/16/32 bits, then sign- or zero-extending to 32 bits.
REQ-026 SHALL pulse resp_valid for exactly one cycle in RESP, then return to IDLE; no back-pressure on the response.
REQ-027 SHALL count RD_WAIT cycles; if TIMEOUT cycles pass without mem_valid, go to RESP with resp_err=1 and resp_rdata=0.
REQ-028 SHALL ignore mem_valid in IDLE, RD_REQ, WR and RESP; a stray pulse has no effect.
REQ-029 SHALL never assert mem_ren and mem_wen in the same cycle.

Reset
REQ-030 SHALL, while rst=0, force state=IDLE, timeout counter=0, captured data=0, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_ren=0, mem_wen=0 and mem_wmask=0.
REQ-031 SHALL abandon any in-flight access on reset with no response; the first accept is possible in the first cycle after rst rises.

Configuration
REQ-032 SHALL, with LSU_MISALIGN_CHECK_EN defined, complete a half access with addr[0]=1 or a word access with addr[1:0]!=0 as IDLE->RESP with resp_err=1, with no mem_ren or mem_wen.
REQ-033 SHALL, without LSU_MISALIGN_CHECK_EN, issue misaligned accesses normally with the masks above; lanes beyond byte 3 are dropped.

Structure
REQ-034 SHALL place the state enum, size encodings (SZ_B, SZ_H, SZ_W) and the lane-mask function in package lsu_pkg.
REQ-035 SHALL implement the shift, mask and extend datapath in a combinational sub-module lsu_align, instantiated once.

Verification
REQ-036 SHALL cover word load: addr=0x80000004, mem responds valid one cycle after ren with 0xDEADBEEF -> resp_rdata=0xDEADBEEF, resp_err=0, total 3 cycles from accept to resp_valid.
REQ-037 SHALL cover signed byte load: addr=0x80000003, mem_rdata=0x80000000 -> resp_rdata=0xFFFFFF80; the same access with req_unsigned=1 -> 0x00000080.
REQ-038 SHALL cover half store: addr=0x80000002, wdata=0x1234ABCD -> mem_wen for one cycle, mem_wmask=0x0C, mem_wdata=0xABCD0000, mem_addr=0x80000000.
REQ-039 SHALL cover timeout: a load with mem_valid held at 0 -> resp_valid with resp_err=1 and resp_rdata=0 exactly TIMEOUT cycles after entering RD_WAIT.
REQ-040 SHALL cover reset mid-read: rst=0 in RD_WAIT -> all outputs are 0 immediately; after release req_ready=1 and no resp_valid appears.
REQ-041 SHALL cover misalignment with LSU_MISALIGN_CHECK_EN: a word load at 0x80000001 -> resp_err=1 with no mem_ren; without the macro -> mem_ren is issued.
